// File: rtl/l4_stream_reader_if.sv
// Valid/ready stream carrying one indexed activation word per transfer.
interface l4_stream_reader_if #(
    parameter int unsigned DW    = 18,
    parameter int unsigned IDX_W = 6
);
    logic [DW-1:0]    out_data;
    logic [IDX_W-1:0] out_idx;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;

    modport master (
        output out_data,
        output out_idx,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_idx,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/l4_stream_reader.sv
// Snapshots the layer-4 activation RAM read bus on start, then streams the words
// in index order over a valid/ready handshake with optional ReLU.
module l4_stream_reader #(
    parameter int unsigned N_WORDS = 64,
    parameter int unsigned DW      = 18,
    parameter int unsigned IDX_W   = 6,
    parameter bit          RELU    = 1'b1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start_i,
    input  logic [N_WORDS-1:0][DW-1:0]      din_i,
    l4_stream_reader_if.master              out_if,
    output logic                            busy_o,
    output logic                            done_o
);
    typedef enum logic [1:0] {StIdle, StStream, StDone} state_e;

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N_WORDS - 1);

    state_e                       state_q, state_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [N_WORDS-1:0][DW-1:0]   bank_q;
    logic                         capture;
    logic [DW-1:0]                word;
    logic                         valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            bank_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (capture) begin
                bank_q <= din_i;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    capture = 1'b1;
                    idx_d   = '0;
                    state_d = StStream;
                end
            end
            StStream: begin
                if (out_if.out_ready) begin
                    if (idx_q == LastIdx) begin
                        idx_d   = '0;
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs depend only on registered state so out_ready never reaches them.
    always_comb begin
        valid            = (state_q == StStream);
        word             = bank_q[idx_q];
        out_if.out_valid = valid;
        out_if.out_idx   = valid ? idx_q : '0;
        out_if.out_last  = valid && (idx_q == LastIdx);
        out_if.out_data  = '0;
        if (valid && !(RELU && word[DW-1])) begin
            out_if.out_data = word;
        end
        busy_o = (state_q != StIdle);
        done_o = (state_q == StDone);
    end
endmodule
